// File: rtl/gun_heat_manager.sv
// gun_heat_manager: per-gun saturating heat tracking with shared fire/cool tick dividers and overheat lockout
module gun_heat_manager #(
    parameter int NUM_GUNS     = 2,
    parameter int HEAT_W       = 4,
    parameter int HEAT_MAX     = 15,
    parameter int UNLOCK_LEVEL = 4,
    parameter int DIV_W        = 28,
    parameter int FIRE_DIV     = 50_000_000,
    parameter int COOL_DIV     = 100_000_000
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start_game,
    input  logic [NUM_GUNS-1:0]        shoot,
    output logic [NUM_GUNS*HEAT_W-1:0] heat,
    output logic [NUM_GUNS-1:0]        overheated,
    output logic [NUM_GUNS-1:0]        fire_pulse,
    output logic                       fire_tick,
    output logic                       cool_tick
);
    localparam logic [DIV_W-1:0]  FIRE_LAST = DIV_W'(FIRE_DIV - 1);
    localparam logic [DIV_W-1:0]  COOL_LAST = DIV_W'(COOL_DIV - 1);
    localparam logic [DIV_W-1:0]  D_ONE     = DIV_W'(1);
    localparam logic [HEAT_W-1:0] H_ONE     = HEAT_W'(1);
    localparam logic [HEAT_W-1:0] H_PRE     = HEAT_W'(HEAT_MAX - 1);
    localparam logic [HEAT_W-1:0] H_UNL_P1  = HEAT_W'(UNLOCK_LEVEL + 1);

    typedef enum logic {READY, LOCKED} state_t;

    logic [DIV_W-1:0]  fire_cnt, cool_cnt;
    state_t            state_q [NUM_GUNS];
    state_t            state_d [NUM_GUNS];
    logic [HEAT_W-1:0] heat_q  [NUM_GUNS];
    logic [HEAT_W-1:0] heat_d  [NUM_GUNS];
    logic [NUM_GUNS-1:0] pulse_d;

    // Tick is registered one count early so it is high while the counter sits at 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fire_cnt  <= FIRE_LAST;
            cool_cnt  <= COOL_LAST;
            fire_tick <= 1'b0;
            cool_tick <= 1'b0;
        end else if (start_game) begin
            fire_cnt  <= FIRE_LAST;
            cool_cnt  <= COOL_LAST;
            fire_tick <= 1'b0;
            cool_tick <= 1'b0;
        end else begin
            fire_cnt  <= (fire_cnt == '0) ? FIRE_LAST : fire_cnt - D_ONE;
            cool_cnt  <= (cool_cnt == '0) ? COOL_LAST : cool_cnt - D_ONE;
            fire_tick <= fire_cnt == D_ONE;
            cool_tick <= cool_cnt == D_ONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_GUNS; i++) begin
                state_q[i] <= READY;
                heat_q[i]  <= '0;
            end
            fire_pulse <= '0;
        end else if (start_game) begin
            for (int i = 0; i < NUM_GUNS; i++) begin
                state_q[i] <= READY;
                heat_q[i]  <= '0;
            end
            fire_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_GUNS; i++) begin
                state_q[i] <= state_d[i];
                heat_q[i]  <= heat_d[i];
            end
            fire_pulse <= pulse_d;
        end
    end

    // A shot wins over cooling when both ticks coincide; a locked gun only cools.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_GUNS; i++) begin
            state_d[i] = state_q[i];
            heat_d[i]  = heat_q[i];
            if (state_q[i] == READY) begin
                if (fire_tick && shoot[i]) begin
                    heat_d[i]  = heat_q[i] + H_ONE;
                    pulse_d[i] = 1'b1;
                    state_d[i] = (heat_q[i] == H_PRE) ? LOCKED : READY;
                end else if (cool_tick && !shoot[i] && heat_q[i] != '0) begin
                    heat_d[i] = heat_q[i] - H_ONE;
                end
            end else if (cool_tick && heat_q[i] != '0) begin
                heat_d[i]  = heat_q[i] - H_ONE;
                state_d[i] = (heat_q[i] <= H_UNL_P1) ? READY : LOCKED;
            end
        end
    end

    always_comb begin
        heat       = '0;
        overheated = '0;
        for (int i = 0; i < NUM_GUNS; i++) begin
            heat[i*HEAT_W +: HEAT_W] = heat_q[i];
            overheated[i]            = state_q[i] == LOCKED;
        end
    end
endmodule

// File: doc/gun_heat_manager.md
Name: gun_heat_manager

Overview:
- Parametrised, multi-gun successor to the single-gun cooldown counter.
- Tracks a saturating heat level per gun, driven by two shared tick dividers: a fire-rate divider and a cool-rate divider.
- Adds an overheat lockout with hysteresis and a per-gun fire pulse.
- Sits between the player/enemy shoot controls and the projectile spawner and HUD heat-bar drawer.

Parameters:
- NUM_GUNS, 2, number of independent gun channels.
- HEAT_W, 4, width of each heat counter.
- HEAT_MAX, 15, saturation/lockout level; must satisfy HEAT_MAX <= 2^HEAT_W-1.
- UNLOCK_LEVEL, 4, heat at or below which a locked gun re-arms; must satisfy UNLOCK_LEVEL < HEAT_MAX.
- DIV_W, 28, width of the divider counters.
- FIRE_DIV, 50_000_000, clock cycles per fire tick (1 Hz at 50 MHz); must be >= 2.
- COOL_DIV, 100_000_000, clock cycles per cool tick (0.5 Hz); must be >= 2.

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  reset; asynchronous, active-low.
- start_game  in  1  synchronous clear at game start.
- shoot  in  NUM_GUNS  per-gun fire request, level-sensitive.
- heat  out  NUM_GUNS*HEAT_W  packed heat levels; gun i occupies bits [i*HEAT_W +: HEAT_W].
- overheated  out  NUM_GUNS  1 while gun i is in LOCKED.
- fire_pulse  out  NUM_GUNS  one-cycle pulse for each shot actually emitted.
- fire_tick  out  1  registered fire-divider tick (debug/HUD).
- cool_tick  out  1  registered cool-divider tick.

Behaviour:
- Reset (resetn=0, async):
  - heat=0, overheated=0, fire_pulse=0, ticks=0, all guns READY.
  - Divider counters load FIRE_DIV-1 and COOL_DIV-1.
- start_game=1 (sync):
  - Same effect as reset on the next edge; overrides every other event that cycle.
  - No fire_pulse is issued on that edge.
- Dividers:
  - Each counter decrements once per clock.
  - At 0 it asserts its tick for exactly one cycle and reloads DIV-1.
  - First fire_tick is high in cycle FIRE_DIV-1 after release (cycles counted from 0); period is FIRE_DIV.
  - cool_tick behaves identically with COOL_DIV.
  - Per-gun logic samples the tick registers, so tick and action fall on the same clock edge.
- Per-gun FSM, READY:
  - fire_tick & shoot[i]: heat+1, fire_pulse[i]=1 next cycle.
  - If the new heat equals HEAT_MAX, go to LOCKED on the same edge; the shot that reaches HEAT_MAX is still emitted.
  - cool_tick & !shoot[i]: heat-1, floor 0.
  - Both ticks in the same cycle: shoot[i]=1 gives increment only; shoot[i]=0 gives decrement only.
  - shoot held with only a cool tick: no change.
- Per-gun FSM, LOCKED:
  - shoot[i] is ignored and no fire_pulse is issued.
  - cool_tick: heat-1 regardless of shoot[i].
  - When the new heat <= UNLOCK_LEVEL, go to READY on the same edge; overheated[i] drops that edge.
  - A fire_tick in the same cycle as unlock does not fire; the next fire_tick can.
- Arithmetic:
  - Heat saturates at HEAT_MAX and 0; it never wraps.
  - Only HEAT_W-bit compares are used, with no intermediate overflow.
- Independence: guns share only the ticks; one gun's state never affects another's.
- Output registration: all outputs are registered; overheated[i] = (state==LOCKED).
- Reset mid-operation: asynchronous clear wins immediately, including a tick or pulse in flight.

Test Plan (sim overrides: FIRE_DIV=4, COOL_DIV=8, HEAT_W=4, HEAT_MAX=15, UNLOCK_LEVEL=4, NUM_GUNS=2):
- Release resetn, shoot=2'b01 held → fire_tick every 4 cycles; heat0 = 1,2,3… with a one-cycle fire_pulse[0] each step; heat1 stays 0.
- Hold shoot[0] until heat0=15 → overheated[0]=1 on the 15th fire tick; later fire ticks give no pulse; heat0 stays 15 until a cool tick.
- Locked gun with shoot[0] still high → heat0 decrements on each cool tick 15→…→4; overheated[0] clears on the edge where heat0 becomes 4; the next fire_tick yields heat0=5 plus a pulse.
- Cycle with fire_tick and cool_tick coincident (every 8 cycles): shoot[1]=1 → heat1+1; shoot[1]=0 → heat1-1. At heat 0 with shoot=0, heat stays 0 (no wrap to 15).
- Assert start_game with heat0=9 and gun 1 locked → next edge: heat=0, overheated=0, no pulse; dividers restart, so the first fire_tick comes 4 cycles after deassertion.
- Pulse resetn low asynchronously between clock edges mid-operation → outputs clear before the next edge; behaviour after release is identical to the first scenario.
